flag_quad_anim: RTL and testbench
=================================

FLAG_QUAD_ANIM -- requirements
Module: flag_quad_anim

Interface
REQ-001 SHALL have parameter COLOR_W, default 6, width of color.
REQ-002 SHALL have parameters CX, default 320, and CY, default 240: centre point.
REQ-003 SHALL have parameters RMIN, default 40, RMAX, default 200, STEP, default 8: star radius limits and per-frame step; legal values are 1<=RMIN<RMAX<=255 and STEP>=1.
REQ-004 SHALL have parameter HOLD, default 30, frames held at each radius extreme; legal HOLD>=1.
REQ-005 SHALL have parameter ROT_FRAMES, default 60, frames per quadrant-colour rotation step; legal ROT_FRAMES>=1.
REQ-006 SHALL have parameters WHITE, default 6'b111111, and Q0..Q3, defaults 6'b000000, 6'b001100, 6'b101010, 6'b100110: star and quadrant colours.
REQ-007 clk  input  1  pixel clock, all state on rising edge.
REQ-008 reset  input  1  synchronous, active-high.
REQ-009 pix_x  input  10  current pixel column.
REQ-010 pix_y  input  10  current pixel row.
REQ-011 mode  input  2  bit0 enables pulse; bit1 enables rotate.
REQ-012 color  output  COLOR_W  registered pixel colour.

Function
REQ-013 Geometry: dx=|pix_x-CX| and dy=|pix_y-CY|, both 10-bit unsigned; products 4*dx and 4*dy computed at 12 bits, with no truncation.
REQ-014 Star hit: dx<R and dy<R and (4*dx < R-dy or R-dx > 4*dy), where R is the current radius register (8 bit).
REQ-015 Quadrant index: 0 when pix_x<CX and pix_y<CY; 1 when pix_x>=CX and pix_y<CY; 2 when pix_x>=CX and pix_y>=CY; 3 otherwise.
REQ-016 Colour select: WHITE on star hit; otherwise Q[(index+rot) mod 4], where rot is a 2-bit rotation register.
REQ-017 Latency: color SHALL be registered, exactly 1 clk after the pix_x/pix_y sample, using the R and rot values present in the sample cycle.
REQ-018 Frame event: a cycle where pix_x==0 and pix_y==0 and the previous cycle's coordinates were not (0,0); at most one event per frame. All R/FSM/rot updates SHALL occur only on frame events.
REQ-019 mode SHALL be sampled only on frame events.
REQ-020 Pulse FSM states: GROW, HOLD_MAX, SHRINK, HOLD_MIN.
REQ-021 GROW: on each event R<=R+STEP; if R+STEP>=RMAX, R<=RMAX, hold_cnt<=HOLD-1, go to HOLD_MAX. The compare SHALL be computed at 9 bits so it cannot wrap.
REQ-022 HOLD_MAX: if hold_cnt==0, go to SHRINK; else hold_cnt decrements.
REQ-023 SHRINK: R<=R-STEP; if R<=RMIN+STEP, R<=RMIN, hold_cnt<=HOLD-1, go to HOLD_MIN. R SHALL never underflow.
REQ-024 HOLD_MIN: mirrors HOLD_MAX, exiting to GROW.
REQ-025 Pulse disabled (mode[0]=0) on an event: R<=RMAX, state<=HOLD_MAX, hold_cnt<=HOLD-1. Re-enabling resumes from HOLD_MAX.
REQ-026 Rotate enabled on an event: rot_cnt increments; when rot_cnt==ROT_FRAMES-1, rot_cnt<=0 and rot<=rot+1, wrapping 3 to 0.
REQ-027 Rotate disabled on an event: rot<=0 and rot_cnt<=0.
REQ-028 Pixel and frame-event paths SHALL be independent: the pixel at (0,0) in an event cycle uses the pre-update R and rot.

Reset
REQ-029 While reset=1, on each clk edge: color<=0, R<=RMIN, state<=GROW, hold_cnt<=0, rot<=0, rot_cnt<=0, previous-coordinate register <= (0,0).
REQ-030 Reset asserted mid-frame or mid-FSM SHALL override every update in the same cycle.
REQ-031 The first frame event after reset release requires coordinates to leave (0,0) first.

Verification
REQ-032 Reset, mode=0, one frame event, then probe: (320,240)->WHITE; (100,100)->Q0; (500,100)->Q1; (500,400)->Q2; (100,400)->Q3, each 1 clk after presentation.
REQ-033 Reset, mode=1, count events: R steps 40,48,...,200 (RMAX reached on the 20th event); holds 30 events; shrinks 200->40 over 20 events; holds 30 events; then grows again.
REQ-034 mode=2, pulse off: after 60 events TL pixel (100,100) shows Q1; after 240 events it shows Q0 again (rot wrap).
REQ-035 Boundary: pix_x=CX=320 with pix_y=100 far from the star (R=40) -> right quadrant Q1; pixel (320,200) with R=40 (dy=40) -> not star.
REQ-036 Holding (0,0) for 3 consecutive cycles -> exactly one frame event.
REQ-037 Assert reset during SHRINK with R=120 -> next cycle color=0 and R=40 in GROW; mode=1 resumes the sequence of REQ-033.

Source files
------------

// File: rtl/flag_quad_anim.sv
// ============================================================================
// Module   : flag_quad_anim
// Brief    : Animated four-quadrant flag with a pulsing white star at the
//            centre and optional rotation of the quadrant colours.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module flag_quad_anim #(
  parameter int                   COLOR_W    = 6,
  parameter int                   CX         = 320,
  parameter int                   CY         = 240,
  parameter int                   RMIN       = 40,
  parameter int                   RMAX       = 200,
  parameter int                   STEP       = 8,
  parameter int                   HOLD       = 30,
  parameter int                   ROT_FRAMES = 60,
  parameter logic [COLOR_W-1:0]   WHITE      = 6'b111111,
  parameter logic [COLOR_W-1:0]   Q0         = 6'b000000,
  parameter logic [COLOR_W-1:0]   Q1         = 6'b001100,
  parameter logic [COLOR_W-1:0]   Q2         = 6'b101010,
  parameter logic [COLOR_W-1:0]   Q3         = 6'b100110
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         pix_x,
  input  logic [9:0]         pix_y,
  input  logic [1:0]         mode,
  output logic [COLOR_W-1:0] color
);

  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int ROT_W  = (ROT_FRAMES > 1) ? $clog2(ROT_FRAMES) : 1;

  localparam logic [9:0]        c_CX      = 10'(CX);
  localparam logic [9:0]        c_CY      = 10'(CY);
  localparam logic [7:0]        c_RMIN    = 8'(RMIN);
  localparam logic [7:0]        c_RMAX    = 8'(RMAX);
  localparam logic [7:0]        c_STEP8   = 8'(STEP);
  localparam logic [8:0]        c_STEP9   = 9'(STEP);
  localparam logic [HOLD_W-1:0] c_HOLD_M1 = HOLD_W'(HOLD - 1);
  localparam logic [ROT_W-1:0]  c_ROT_M1  = ROT_W'(ROT_FRAMES - 1);

  typedef enum logic [1:0] {
    S_GROW     = 2'd0,
    S_HOLD_MAX = 2'd1,
    S_SHRINK   = 2'd2,
    S_HOLD_MIN = 2'd3
  } state_t;

  // Animation state
  state_t             r_state;
  logic [7:0]         r_radius;
  logic [HOLD_W-1:0]  r_hold;
  logic [1:0]         r_rot;
  logic [ROT_W-1:0]   r_rot_cnt;
  logic [9:0]         r_prev_x;
  logic [9:0]         r_prev_y;

  // Next-state values
  state_t             w_state_nxt;
  logic [7:0]         w_radius_nxt;
  logic [HOLD_W-1:0]  w_hold_nxt;
  logic [1:0]         w_rot_nxt;
  logic [ROT_W-1:0]   w_rot_cnt_nxt;

  // Pixel path
  logic               w_right;
  logic               w_bottom;
  logic [9:0]         w_dx;
  logic [9:0]         w_dy;
  logic [11:0]        w_dx12;
  logic [11:0]        w_dy12;
  logic [11:0]        w_dx4;
  logic [11:0]        w_dy4;
  logic [11:0]        w_r12;
  logic [11:0]        w_r_minus_dx;
  logic [11:0]        w_r_minus_dy;
  logic               w_hit;
  logic [1:0]         w_quad;
  logic [1:0]         w_sel;
  logic [COLOR_W-1:0] w_qcol;
  logic [COLOR_W-1:0] w_pix_color;

  // Frame event and pulse arithmetic
  logic               w_frame_evt;
  logic [8:0]         w_sum9;
  logic [8:0]         w_thr9;

  // Geometry: absolute distances to the centre, 12-bit products and star test
  always_comb begin
    w_right      = (pix_x >= c_CX);
    w_bottom     = (pix_y >= c_CY);
    w_dx         = w_right  ? (pix_x - c_CX) : (c_CX - pix_x);
    w_dy         = w_bottom ? (pix_y - c_CY) : (c_CY - pix_y);
    w_dx12       = {2'b00, w_dx};
    w_dy12       = {2'b00, w_dy};
    w_dx4        = {w_dx, 2'b00};
    w_dy4        = {w_dy, 2'b00};
    w_r12        = {4'd0, r_radius};
    // Differences are only consulted when dx<R and dy<R, so they never wrap
    w_r_minus_dx = w_r12 - w_dx12;
    w_r_minus_dy = w_r12 - w_dy12;
    w_hit        = (w_dx12 < w_r12) && (w_dy12 < w_r12) &&
                   ((w_dx4 < w_r_minus_dy) || (w_r_minus_dx > w_dy4));
  end

  // Quadrant index, rotated colour lookup and final pixel colour
  always_comb begin
    w_quad = 2'd0;
    case ({w_bottom, w_right})
      2'b00:   w_quad = 2'd0;
      2'b01:   w_quad = 2'd1;
      2'b11:   w_quad = 2'd2;
      default: w_quad = 2'd3;
    endcase
    w_sel  = w_quad + r_rot;
    w_qcol = Q0;
    case (w_sel)
      2'd0:    w_qcol = Q0;
      2'd1:    w_qcol = Q1;
      2'd2:    w_qcol = Q2;
      default: w_qcol = Q3;
    endcase
    w_pix_color = w_hit ? WHITE : w_qcol;
  end

  // Frame event: first cycle at (0,0) after any other coordinate
  always_comb begin
    w_frame_evt = (pix_x == 10'd0) && (pix_y == 10'd0) &&
                  !((r_prev_x == 10'd0) && (r_prev_y == 10'd0));
  end

  // Pulse FSM next-state: radius and hold counter evolve once per frame
  always_comb begin
    w_state_nxt  = r_state;
    w_radius_nxt = r_radius;
    w_hold_nxt   = r_hold;
    w_sum9       = {1'b0, r_radius} + c_STEP9;
    w_thr9       = {1'b0, c_RMIN} + c_STEP9;
    if (!mode[0]) begin
      w_radius_nxt = c_RMAX;
      w_state_nxt  = S_HOLD_MAX;
      w_hold_nxt   = c_HOLD_M1;
    end else begin
      case (r_state)
        S_GROW: begin
          if (w_sum9 >= {1'b0, c_RMAX}) begin
            w_radius_nxt = c_RMAX;
            w_hold_nxt   = c_HOLD_M1;
            w_state_nxt  = S_HOLD_MAX;
          end else begin
            w_radius_nxt = w_sum9[7:0];
          end
        end
        S_HOLD_MAX: begin
          if (r_hold == '0) w_state_nxt = S_SHRINK;
          else              w_hold_nxt  = r_hold - HOLD_W'(1);
        end
        S_SHRINK: begin
          // Clamp before subtracting so the radius cannot underflow
          if ({1'b0, r_radius} <= w_thr9) begin
            w_radius_nxt = c_RMIN;
            w_hold_nxt   = c_HOLD_M1;
            w_state_nxt  = S_HOLD_MIN;
          end else begin
            w_radius_nxt = r_radius - c_STEP8;
          end
        end
        S_HOLD_MIN: begin
          if (r_hold == '0) w_state_nxt = S_GROW;
          else              w_hold_nxt  = r_hold - HOLD_W'(1);
        end
        default: w_state_nxt = S_GROW;
      endcase
    end
  end

  // Rotation next-state: advance one quadrant every ROT_FRAMES frames
  always_comb begin
    w_rot_nxt     = r_rot;
    w_rot_cnt_nxt = r_rot_cnt;
    if (mode[1]) begin
      if (r_rot_cnt == c_ROT_M1) begin
        w_rot_cnt_nxt = '0;
        w_rot_nxt     = r_rot + 2'd1;
      end else begin
        w_rot_cnt_nxt = r_rot_cnt + ROT_W'(1);
      end
    end else begin
      w_rot_nxt     = 2'd0;
      w_rot_cnt_nxt = '0;
    end
  end

  // Registered pixel colour, one clock after the coordinate sample
  always_ff @(posedge clk) begin
    if (reset) color <= '0;
    else       color <= w_pix_color;
  end

  // Animation registers, committed only on frame events
  always_ff @(posedge clk) begin
    if (reset) begin
      r_radius  <= c_RMIN;
      r_state   <= S_GROW;
      r_hold    <= '0;
      r_rot     <= 2'd0;
      r_rot_cnt <= '0;
      r_prev_x  <= 10'd0;
      r_prev_y  <= 10'd0;
    end else begin
      r_prev_x <= pix_x;
      r_prev_y <= pix_y;
      if (w_frame_evt) begin
        r_radius  <= w_radius_nxt;
        r_state   <= w_state_nxt;
        r_hold    <= w_hold_nxt;
        r_rot     <= w_rot_nxt;
        r_rot_cnt <= w_rot_cnt_nxt;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_flag_quad_anim.sv
// ============================================================================
// Module   : tb_flag_quad_anim
// Brief    : Self-checking bench for flag_quad_anim against a schedule-based
//            behavioural model of the pulse and rotation animation.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_flag_quad_anim;

  localparam int CX = 320;
  localparam int CY = 240;
  localparam int RMIN = 40;
  localparam int RMAX = 200;
  localparam int STEP = 8;
  localparam int HOLD = 30;
  localparam int ROT_FRAMES = 60;
  localparam int WHITE = 6'b111111;
  localparam int Q0 = 6'b000000;
  localparam int Q1 = 6'b001100;
  localparam int Q2 = 6'b101010;
  localparam int Q3 = 6'b100110;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [1:0] mode;
  logic [5:0] color;

  int n_checks = 0;
  int n_err    = 0;

  // Model: radius follows a precomputed per-event schedule of one full cycle
  int sched[$];
  int sched_len;
  int reset_pos;
  int m_r;
  int m_pos;
  int m_rotn;
  int prevx;
  int prevy;
  int qtab[4];

  flag_quad_anim dut (
    .clk   (clk),
    .reset (reset),
    .pix_x (pix_x),
    .pix_y (pix_y),
    .mode  (mode),
    .color (color)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Schedule starts right after entering the max hold; entry i is R after event i
  task automatic build_sched();
    int r;
    sched = {};
    repeat (HOLD) sched.push_back(RMAX);
    r = RMAX;
    do begin
      r = (r <= RMIN + STEP) ? RMIN : r - STEP;
      sched.push_back(r);
    end while (r != RMIN);
    repeat (HOLD) sched.push_back(RMIN);
    reset_pos = sched.size();
    r = RMIN;
    do begin
      r = (r + STEP >= RMAX) ? RMAX : r + STEP;
      sched.push_back(r);
    end while (r != RMAX);
    sched_len = sched.size();
  endtask

  function automatic int exp_color(int x, int y);
    int dx, dy, q;
    bit hit;
    dx  = (x >= CX) ? x - CX : CX - x;
    dy  = (y >= CY) ? y - CY : CY - y;
    hit = (dx < m_r) && (dy < m_r) && ((4*dx < m_r - dy) || (m_r - dx > 4*dy));
    if (x < CX && y < CY)       q = 0;
    else if (x >= CX && y < CY) q = 1;
    else if (x >= CX)           q = 2;
    else                        q = 3;
    if (hit) return WHITE;
    return qtab[(q + m_rotn / ROT_FRAMES) % 4];
  endfunction

  task automatic model_event(input logic [1:0] m);
    if (m[0]) begin
      m_r   = sched[m_pos];
      m_pos = (m_pos + 1) % sched_len;
    end else begin
      m_r   = RMAX;
      m_pos = 0;
    end
    if (m[1]) m_rotn = (m_rotn + 1) % (4 * ROT_FRAMES);
    else      m_rotn = 0;
  endtask

  task automatic do_reset(input int x, input int y);
    reset = 1'b1;
    pix_x = 10'(x);
    pix_y = 10'(y);
    @(posedge clk); #1;
    chk("reset_color", 32'(color), 32'd0);
    m_r    = RMIN;
    m_pos  = reset_pos;
    m_rotn = 0;
    prevx  = 0;
    prevy  = 0;
    reset  = 1'b0;
  endtask

  // Present one pixel, check its colour one clock later, then advance the model
  task automatic px(input string tag, input int x, input int y);
    int  e;
    bit  evt;
    pix_x = 10'(x);
    pix_y = 10'(y);
    e   = exp_color(x, y);
    evt = (x == 0 && y == 0) && !(prevx == 0 && prevy == 0);
    @(posedge clk); #1;
    chk(tag, 32'(color), 32'(e));
    if (evt) model_event(mode);
    prevx = x;
    prevy = y;
  endtask

  task automatic pxe(input string tag, input int x, input int y, input int expv);
    px(tag, x, y);
    chk(tag, 32'(color), 32'(expv));
  endtask

  // Probe just inside and just outside the star along the vertical axis
  task automatic probe_r(input string tag);
    int r;
    r = m_r;
    px(tag, CX, CY - r + 1);
    px(tag, CX, CY - r);
  endtask

  task automatic rand_frame(input string tag);
    int n, x, y, span;
    n = int'($urandom_range(1, 4));
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        x = int'($urandom_range(1, 639));
        y = int'($urandom_range(0, 479));
      end else begin
        span = 2 * m_r + 4;
        x = CX - m_r - 2 + int'($urandom_range(0, span));
        y = CY - m_r - 2 + int'($urandom_range(0, span));
      end
      px(tag, x, y);
    end
    px(tag, 0, 0);
  endtask

  initial begin
    int  ev;
    bit  found;
    qtab = '{Q0, Q1, Q2, Q3};
    build_sched();
    mode  = 2'd0;
    pix_x = 10'd0;
    pix_y = 10'd0;
    do_reset(0, 0);
    do_reset(0, 0);

    // Fresh reset: (0,0) is not an event, R=40 boundaries
    do_reset(5, 5);
    mode = 2'd0;
    px("no_evt_after_rst", 0, 0);
    pxe("bnd_x_eq_cx", 320, 100, Q1);
    pxe("bnd_dy_eq_r", 320, 200, Q1);
    pxe("bnd_dy_r_m1", 320, 201, WHITE);

    // Pulse off, one event, quadrant probes
    px("pre_evt", 10, 10);
    px("evt", 0, 0);
    pxe("probe_centre", 320, 240, WHITE);
    pxe("probe_tl", 100, 100, Q0);
    pxe("probe_tr", 500, 100, Q1);
    pxe("probe_br", 500, 400, Q2);
    pxe("probe_bl", 100, 400, Q3);

    // Full pulse cycle
    do_reset(9, 9);
    mode = 2'd1;
    for (ev = 1; ev <= 210; ev++) begin
      px("pulse", 100, 300);
      px("pulse", 0, 0);
      probe_r("pulse_r");
      if (ev == 20 || ev == 50) begin
        pxe("rmax_in", 320, 41, WHITE);
        pxe("rmax_out", 320, 40, Q1);
      end
      if (ev == 70 || ev == 100) begin
        pxe("rmin_in", 320, 201, WHITE);
        pxe("rmin_out", 320, 200, Q1);
      end
    end

    // (0,0) held for three cycles gives a single event
    px("hold00", 7, 7);
    px("hold00", 0, 0);
    px("hold00", 0, 0);
    px("hold00", 0, 0);
    probe_r("hold00_r");

    // Reset during shrink at R=120
    do_reset(3, 3);
    mode  = 2'd1;
    found = 1'b0;
    for (int f = 0; f < 300 && !found; f++) begin
      px("seek", 100, 300);
      px("seek", 0, 0);
      if (m_r == 120 && m_pos - 1 >= HOLD && m_pos - 1 < reset_pos - HOLD) found = 1'b1;
    end
    chk("seek_r120", 32'(found), 32'd1);
    px("pre_rst", 50, 50);
    do_reset(0, 0);
    pxe("after_rst_r40_in", 320, 201, WHITE);
    pxe("after_rst_r40_out", 320, 200, Q1);
    for (int f = 0; f < 30; f++) begin
      px("resume", 100, 300);
      px("resume", 0, 0);
      probe_r("resume_r");
    end

    // Rotation with pulse off
    do_reset(1, 1);
    mode = 2'd2;
    for (ev = 1; ev <= 240; ev++) begin
      px("rot", 100, 300);
      px("rot", 0, 0);
      if (ev == 60)  pxe("rot_q1", 100, 100, Q1);
      if (ev == 240) pxe("rot_wrap", 100, 100, Q0);
    end

    // Randomized frames with mode changes and occasional resets
    do_reset(2, 2);
    for (int f = 0; f < 400; f++) begin
      if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0)
        do_reset(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
      rand_frame("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
